board_cursor_ctrl: RTL and testbench

//  Upstream input stage for the checkers game logic. Debounces five raw active-low pushbuttons,

---
 rtl/checker_pkg.sv | 15 +
 rtl/btn_debounce.sv | 42 ++++
 rtl/board_cursor_ctrl.sv | 111 +++++++++++
 tb/tb_board_cursor_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/checker_pkg.sv
// checker_pkg: shared widths, FSM state encoding and location helpers for the checkers input stage
// Location encoding is {x[2:0], y[2:0]}; loc_x()/loc_y() split a location into its coordinates.
package checker_pkg;
    localparam int LOC_W     = 6;
    localparam int COORD_W   = 3;
    localparam int NUM_SLOTS = 4;
    localparam int SLOT_W    = 7;
    typedef enum logic [1:0] {PICK, PLACE, COOLDOWN} state_t;
    function automatic logic [COORD_W-1:0] loc_x(input logic [LOC_W-1:0] loc);
        return loc[LOC_W-1:COORD_W];
    endfunction
    function automatic logic [COORD_W-1:0] loc_y(input logic [LOC_W-1:0] loc);
        return loc[COORD_W-1:0];
    endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronizes and debounces one raw active-low pushbutton
// Ports:
//   clk, rst  clock and asynchronous active-low reset
//   btn_n     raw pushbutton, active-low, asynchronous
//   pressed   debounced level, 1 = held
//   press_evt 1-cycle pulse on the debounced released->pressed edge
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic pressed,
    output logic press_evt
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic s1, s2, differ;
    logic [CW-1:0] cnt;
    // the counter only runs while the synchronized level disagrees with the accepted level
    assign differ = (~s2) != pressed;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1        <= 1'b1;
            s2        <= 1'b1;
            cnt       <= '0;
            pressed   <= 1'b0;
            press_evt <= 1'b0;
        end else begin
            s1        <= btn_n;
            s2        <= s1;
            press_evt <= differ && cnt == LAST && !pressed;
            if (!differ)
                cnt <= '0;
            else if (cnt == LAST) begin
                cnt     <= '0;
                pressed <= ~pressed;
            end else
                cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/board_cursor_ctrl.sv
// board_cursor_ctrl: debounced 8x8 board cursor and pick/place select front end for the checkers game logic
// Ports:
//   clk, rst                 clock and asynchronous active-low reset
//   btn_*_n                  raw active-low pushbuttons (up, down, left, right, sel)
//   legal_move               4 slots x {valid, loc[5:0]} from the game logic
//   cursor_loc               current cursor location
//   select_loc               location presented to the game logic, changes only on accepted selects
//   place_phase              1 while a piece is picked and awaiting its destination
//   sel_strobe/reject_strobe 1-cycle pulses for accepted/refused select presses
// Build option: LEGAL_FILTER_EN makes a place commit require a matching valid legal_move slot.
module board_cursor_ctrl
    import checker_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int COOLDOWN_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_up_n,
    input  logic        btn_down_n,
    input  logic        btn_left_n,
    input  logic        btn_right_n,
    input  logic        btn_sel_n,
    input  logic [27:0] legal_move,
    output logic [5:0]  cursor_loc,
    output logic [5:0]  select_loc,
    output logic        place_phase,
    output logic        sel_strobe,
    output logic        reject_strobe
);
    localparam int CDW = $clog2(COOLDOWN_CYCLES + 1);
    localparam logic [CDW-1:0] CD_LOAD = CDW'(COOLDOWN_CYCLES);
    logic [4:0] btn_n, evt, level_unused;
    logic [COORD_W-1:0] dx, dy;
    logic [LOC_W-1:0] select_n;
    logic [CDW-1:0] cd, cd_n;
    logic sel_n, rej_n, legal;
    state_t state, state_n;
    assign btn_n = {btn_sel_n, btn_right_n, btn_left_n, btn_down_n, btn_up_n};
    for (genvar i = 0; i < 5; i++) begin : gen_db
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk(clk),
            .rst(rst),
            .btn_n(btn_n[i]),
            .pressed(level_unused[i]),
            .press_evt(evt[i])
        );
    end
    // opposite moves in the same cycle cancel; adding '1 is a wrapping decrement
    assign dy = evt[0] && !evt[1] ? COORD_W'(1) : evt[1] && !evt[0] ? '1 : '0;
    assign dx = evt[3] && !evt[2] ? COORD_W'(1) : evt[2] && !evt[3] ? '1 : '0;
`ifdef LEGAL_FILTER_EN
    always_comb begin
        legal = 1'b0;
        for (int k = 0; k < NUM_SLOTS; k++)
            legal |= legal_move[SLOT_W*k+LOC_W] && legal_move[SLOT_W*k +: LOC_W] == cursor_loc;
    end
`else
    logic legal_move_unused;
    assign legal_move_unused = ^legal_move;
    assign legal = 1'b1;
`endif
    // actions use the registered (pre-move) cursor_loc even when a move lands in the same cycle
    always_comb begin
        state_n  = state;
        select_n = select_loc;
        cd_n     = cd;
        sel_n    = 1'b0;
        rej_n    = 1'b0;
        case (state)
            PICK: if (evt[4]) begin
                select_n = cursor_loc;
                sel_n    = 1'b1;
                state_n  = PLACE;
            end
            PLACE: if (evt[4]) begin
                if (cursor_loc == select_loc || !legal)
                    rej_n = 1'b1;
                else begin
                    select_n = cursor_loc;
                    sel_n    = 1'b1;
                    cd_n     = CD_LOAD;
                    state_n  = COOLDOWN;
                end
            end
            default: begin
                rej_n = evt[4];
                cd_n  = cd <= CDW'(1) ? '0 : cd - 1'b1;
                state_n = cd <= CDW'(1) ? PICK : COOLDOWN;
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= PICK;
            cursor_loc    <= '0;
            select_loc    <= '0;
            cd            <= '0;
            sel_strobe    <= 1'b0;
            reject_strobe <= 1'b0;
        end else begin
            state         <= state_n;
            cursor_loc    <= {loc_x(cursor_loc) + dx, loc_y(cursor_loc) + dy};
            select_loc    <= select_n;
            cd            <= cd_n;
            sel_strobe    <= sel_n;
            reject_strobe <= rej_n;
        end
    end
    assign place_phase = state == PLACE;
endmodule

// File: tb/tb_board_cursor_ctrl.sv
// tb_board_cursor_ctrl: directed self-checking bench for board_cursor_ctrl
// A second instance with a long cooldown shares the inputs so a select press can land inside its cooldown window.
module tb_board_cursor_ctrl;
    localparam logic [4:0] U = 5'd1, D = 5'd2, L = 5'd4, R = 5'd8, S = 5'd16;
    logic clk = 1'b0, rst = 1'b0;
    logic btn_up_n = 1'b1, btn_down_n = 1'b1, btn_left_n = 1'b1, btn_right_n = 1'b1, btn_sel_n = 1'b1;
    logic [27:0] legal_move = '0;
    logic [5:0] cursor_loc, select_loc, cd_cursor_loc, cd_select_loc;
    logic place_phase, sel_strobe, reject_strobe, cd_place_phase, cd_sel_strobe, cd_reject_strobe;
    logic s_sel, s_rej, c_sel, c_rej;
    int checks = 0, failures = 0;
    always #5 clk = ~clk;
    board_cursor_ctrl #(.DEBOUNCE_CYCLES(4), .COOLDOWN_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .btn_up_n(btn_up_n), .btn_down_n(btn_down_n), .btn_left_n(btn_left_n),
        .btn_right_n(btn_right_n), .btn_sel_n(btn_sel_n), .legal_move(legal_move),
        .cursor_loc(cursor_loc), .select_loc(select_loc), .place_phase(place_phase),
        .sel_strobe(sel_strobe), .reject_strobe(reject_strobe)
    );
    board_cursor_ctrl #(.DEBOUNCE_CYCLES(4), .COOLDOWN_CYCLES(32)) dut_cd (
        .clk(clk), .rst(rst),
        .btn_up_n(btn_up_n), .btn_down_n(btn_down_n), .btn_left_n(btn_left_n),
        .btn_right_n(btn_right_n), .btn_sel_n(btn_sel_n), .legal_move(legal_move),
        .cursor_loc(cd_cursor_loc), .select_loc(cd_select_loc), .place_phase(cd_place_phase),
        .sel_strobe(cd_sel_strobe), .reject_strobe(cd_reject_strobe)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0o exp=%0o", tag, got, exp);
        end
    endtask
    // raw press lands before edge 1; its effect is visible just after edge 2+4+1
    task automatic press(input logic [4:0] m);
        @(negedge clk);
        {btn_sel_n, btn_right_n, btn_left_n, btn_down_n, btn_up_n} = ~m;
        repeat (7) @(posedge clk);
        #1;
        s_sel = sel_strobe;
        s_rej = reject_strobe;
        c_sel = cd_sel_strobe;
        c_rej = cd_reject_strobe;
        {btn_sel_n, btn_right_n, btn_left_n, btn_down_n, btn_up_n} = 5'h1f;
        repeat (12) @(posedge clk);
        #1;
    endtask
    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask
    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        check("rst_cursor", cursor_loc, 6'o00);
        check("rst_select", select_loc, 6'o00);
        check("rst_place", place_phase, 1'b0);
        check("rst_sel_strobe", sel_strobe, 1'b0);
        check("rst_rej_strobe", reject_strobe, 1'b0);
        // bounce: 10 toggles two cycles apart, then held low
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            btn_right_n = ~btn_right_n;
            repeat (2) @(negedge clk);
        end
        btn_right_n = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("bounce_early", cursor_loc, 6'o00);
        @(posedge clk);
        #1;
        check("bounce_move", cursor_loc, 6'o10);
        repeat (20) @(posedge clk);
        #1;
        check("bounce_single", cursor_loc, 6'o10);
        btn_right_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("bounce_release", cursor_loc, 6'o10);
        // wrap-around and cancellation
        pulse_reset();
        #1;
        check("reset2_cursor", cursor_loc, 6'o00);
        press(D);
        check("wrap_down", cursor_loc, 6'o07);
        press(L);
        check("wrap_left", cursor_loc, 6'o77);
        press(U | D);
        check("cancel_ud", cursor_loc, 6'o77);
        press(U | D | R);
        check("cancel_ud_right", cursor_loc, 6'o07);
        press(U);
        check("wrap_up", cursor_loc, 6'o00);
        // pick / place / cooldown
        press(R);
        press(U);
        check("move_11", cursor_loc, 6'o11);
        press(S);
        check("pick_strobe", s_sel, 1'b1);
        check("pick_no_rej", s_rej, 1'b0);
        check("pick_select", select_loc, 6'o11);
        check("pick_phase", place_phase, 1'b1);
        check("pick_strobe_clear", sel_strobe, 1'b0);
        press(R);
        press(U);
        check("move_22", cursor_loc, 6'o22);
        check("move_keeps_select", select_loc, 6'o11);
        press(S);
        check("place_strobe", s_sel, 1'b1);
        check("place_select", select_loc, 6'o22);
        check("place_phase", place_phase, 1'b0);
        check("cd_place_select", cd_select_loc, 6'o22);
        press(S);
        check("cooldown_rej", c_rej, 1'b1);
        check("cooldown_no_sel", c_sel, 1'b0);
        check("cooldown_select", cd_select_loc, 6'o22);
        check("cooldown_phase", cd_place_phase, 1'b0);
        check("after_cd_pick", s_sel, 1'b1);
        check("after_cd_phase", place_phase, 1'b1);
        // same square in PLACE
        press(S);
        check("same_rej", s_rej, 1'b1);
        check("same_no_sel", s_sel, 1'b0);
        check("same_select", select_loc, 6'o22);
        check("same_phase", place_phase, 1'b1);
        // legal-move filter
        pulse_reset();
        legal_move = {7'b0, 7'b0, {1'b1, 6'o22}, 7'b0};
        press(S);
        check("lf_pick_phase", place_phase, 1'b1);
        press(U);
        press(U);
        check("lf_cursor", cursor_loc, 6'o02);
        press(S);
`ifdef LEGAL_FILTER_EN
        check("lf_illegal_rej", s_rej, 1'b1);
        check("lf_illegal_phase", place_phase, 1'b1);
        check("lf_illegal_select", select_loc, 6'o00);
        press(R);
        press(R);
        press(S);
        check("lf_legal_sel", s_sel, 1'b1);
        check("lf_legal_select", select_loc, 6'o22);
        check("lf_legal_phase", place_phase, 1'b0);
`else
        check("lf_off_sel", s_sel, 1'b1);
        check("lf_off_select", select_loc, 6'o02);
        check("lf_off_phase", place_phase, 1'b0);
`endif
        // asynchronous reset in PLACE
        repeat (12) @(posedge clk);
        press(S);
        check("pre_rst_phase", place_phase, 1'b1);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_cursor", cursor_loc, 6'o00);
        check("async_select", select_loc, 6'o00);
        check("async_phase", place_phase, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        press(U);
        check("post_rst_cursor", cursor_loc, 6'o01);
        press(S);
        check("post_rst_pick", s_sel, 1'b1);
        check("post_rst_phase", place_phase, 1'b1);
        check("post_rst_select", select_loc, 6'o01);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
